// File: rtl/ram8_pkg.sv
// Shared constants and types for the byte-serialising store writer.
//   ADDR_W   : byte address width (2048-byte RAM)
//   DATA_W   : request data width (one ARM word)
//   BYTES_PW : bytes per word
//   wr_state_t : IDLE / WRITE / DONE sequencing states
//   wr_req_t   : request fields latched at accept time
package ram8_pkg;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int BYTES_PW = DATA_W / 8;
  localparam int CNT_W    = $clog2(BYTES_PW);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  last;
  } wr_req_t;
endpackage

// File: rtl/ram8_array.sv
// 2^AW x 8 byte storage: one synchronous write port, one asynchronous read port.
//   clk          : write clock
//   we/waddr/wdata : write enable, byte address, byte data (committed on rising edge)
//   raddr/rdata  : combinational read; a same-cycle write is not yet visible
// Contents are deliberately not reset.
module ram8_array
  import ram8_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/ram8_store_writer.sv
// Serialises STR (word) / STRB (byte) store requests into single-byte
// little-endian writes to a 2048x8 RAM, and exposes an async byte read port.
//   clk, rst        : clock, async active-high reset
//   req_valid/ready : request handshake (ready only while idle)
//   req_addr        : byte address; STR is force-aligned to a word boundary
//   req_wdata       : store data; STRB uses [7:0]
//   req_byte        : 1 = STRB, 0 = STR
//   busy            : high while writing or signalling done
//   done            : one-cycle pulse after the last byte commits
//   rd_addr/rd_data : combinational RAM byte read
module ram8_store_writer
  import ram8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_byte,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  wr_state_t        state, state_nx;
  wr_req_t          req_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]       wbyte;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (cnt == req_q.last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latches and byte counter. Word stores clear the low address
  // bits so a word never straddles the top of the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      req_q.base <= req_byte ? req_addr : (req_addr & ~ADDR_W'(BYTES_PW - 1));
      req_q.data <= req_wdata;
      req_q.last <= req_byte ? '0 : CNT_W'(BYTES_PW - 1);
      cnt        <= '0;
    end else if (state == WRITE && cnt != req_q.last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign we    = (state == WRITE);
  assign waddr = req_q.base + {{(ADDR_W-CNT_W){1'b0}}, cnt};
  assign wbyte = req_q.data[8*cnt +: 8];

  ram8_array #(.AW(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wbyte),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule
